// File: rtl/poly_audio_player.sv
// Polyphonic frame-table square-wave player; POLY_AUDIO_TRANSPOSE_EN adds the OCTAVE period shift.
// Outputs registered: BUSY/AUDIO_CH 1 cycle after the deciding edge, AUDIO one more; no backpressure, START dropped while busy.
module poly_audio_player #(
  parameter int CHANNELS     = 2,
  parameter int FRAME_BITS   = 5,
  parameter int PERIOD_WIDTH = 16,
  parameter int DUR_WIDTH    = 10,
  parameter int SEQ_DIV      = 48828,
  parameter int SAMPLE_DIV   = 128,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
`ifdef POLY_AUDIO_TRANSPOSE_EN
  input  logic [1:0]              OCTAVE,
`endif
  input  logic                    WR_EN,
  input  logic [CW-1:0]           WR_CH,
  input  logic [FRAME_BITS-1:0]   WR_ADDR,
  input  logic [PERIOD_WIDTH-1:0] WR_PERIOD,
  input  logic [DUR_WIDTH-1:0]    WR_DUR,
  input  logic                    START,
  input  logic [CHANNELS-1:0]     CH_MASK,
  input  logic                    STOP,
  input  logic                    LOOP,
  output logic [CHANNELS-1:0]     BUSY,
  output logic                    DONE,
  output logic [CHANNELS-1:0]     AUDIO_CH,
  output logic                    AUDIO
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  localparam int DEPTH = 1 << FRAME_BITS;
  localparam int SW    = $clog2(SEQ_DIV + 1);
  localparam int MW    = $clog2(SAMPLE_DIV + 1);
  localparam logic [SW-1:0]           SEQ_LAST = SW'(SEQ_DIV - 1);
  localparam logic [MW-1:0]           SMP_LAST = MW'(SAMPLE_DIV - 1);
  localparam logic [CW:0]             CH_LIM   = (CW + 1)'(CHANNELS);
  localparam logic [PERIOD_WIDTH-1:0] ONE_P    = PERIOD_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] tbl_period [CHANNELS][DEPTH];
  logic [DUR_WIDTH-1:0]    tbl_dur    [CHANNELS][DEPTH];

  state_t                  st     [CHANNELS];
  logic [FRAME_BITS-1:0]   frame  [CHANNELS];
  logic [PERIOD_WIDTH-1:0] per_q  [CHANNELS];
  logic [DUR_WIDTH-1:0]    dur_q  [CHANNELS];
  logic [DUR_WIDTH-1:0]    tick_q [CHANNELS];
  logic [PERIOD_WIDTH-1:0] tone_q [CHANNELS];

  logic [SW-1:0] seq_cnt;
  logic [MW-1:0] smp_cnt;
  logic          busy_q;
  logic          seq_tick;
  logic          smp_tick;
  logic          start_ok;
  logic [1:0]    oct;

`ifdef POLY_AUDIO_TRANSPOSE_EN
  assign oct = OCTAVE;
`else
  assign oct = 2'd0;
`endif

  assign seq_tick = (seq_cnt == SEQ_LAST);
  assign smp_tick = (smp_cnt == SMP_LAST);
  assign start_ok = START && !STOP && (BUSY == '0);

  // A nonzero period must never shift down into a rest.
  function automatic logic [PERIOD_WIDTH-1:0] eff_period(input logic [PERIOD_WIDTH-1:0] p,
                                                         input logic [1:0] o);
    logic [PERIOD_WIDTH-1:0] s;
    s = p >> o;
    if (p != '0 && s == '0) s = ONE_P;
    return s;
  endfunction

  always_ff @(posedge CLK) begin
    if (WR_EN && ({1'b0, WR_CH} < CH_LIM)) begin
      tbl_period[WR_CH][WR_ADDR] <= WR_PERIOD;
      tbl_dur[WR_CH][WR_ADDR]    <= WR_DUR;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      seq_cnt  <= '0;
      smp_cnt  <= '0;
      busy_q   <= 1'b0;
      DONE     <= 1'b0;
      AUDIO    <= 1'b0;
      BUSY     <= '0;
      AUDIO_CH <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        st[c]     <= IDLE;
        frame[c]  <= '0;
        per_q[c]  <= '0;
        dur_q[c]  <= '0;
        tick_q[c] <= '0;
        tone_q[c] <= '0;
      end
    end else begin
      seq_cnt <= (start_ok || seq_tick) ? '0 : seq_cnt + 1'b1;
      smp_cnt <= (start_ok || smp_tick) ? '0 : smp_cnt + 1'b1;
      busy_q  <= |BUSY;
      DONE    <= busy_q && (BUSY == '0);
      AUDIO   <= ^AUDIO_CH;
      for (int c = 0; c < CHANNELS; c++) begin
        if (STOP) begin
          st[c]       <= IDLE;
          BUSY[c]     <= 1'b0;
          AUDIO_CH[c] <= 1'b0;
        end else begin
          case (st[c])
            IDLE: begin
              AUDIO_CH[c] <= 1'b0;
              if (start_ok && CH_MASK[c]) begin
                st[c]    <= LOAD;
                BUSY[c]  <= 1'b1;
                frame[c] <= '0;
              end
            end
            LOAD: begin
              AUDIO_CH[c] <= 1'b0;
              tone_q[c]   <= '0;
              tick_q[c]   <= '0;
              per_q[c]    <= eff_period(tbl_period[c][frame[c]], oct);
              dur_q[c]    <= tbl_dur[c][frame[c]];
              if (tbl_period[c][frame[c]] == '0 && tbl_dur[c][frame[c]] == '0) begin
                if (LOOP) begin
                  frame[c] <= '0;
                end else begin
                  st[c]   <= IDLE;
                  BUSY[c] <= 1'b0;
                end
              end else begin
                st[c] <= PLAY;
              end
            end
            PLAY: begin
              if (seq_tick && tick_q[c] == dur_q[c]) begin
                st[c]       <= LOAD;
                frame[c]    <= frame[c] + 1'b1;
                AUDIO_CH[c] <= 1'b0;
              end else begin
                if (seq_tick) tick_q[c] <= tick_q[c] + 1'b1;
                if (smp_tick && per_q[c] != '0) begin
                  if (tone_q[c] == per_q[c] - ONE_P) begin
                    tone_q[c]   <= '0;
                    AUDIO_CH[c] <= ~AUDIO_CH[c];
                  end else begin
                    tone_q[c] <= tone_q[c] + ONE_P;
                  end
                end
              end
            end
            default: st[c] <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_audio_player.sv
// Scoreboard bench for poly_audio_player: per-cycle expectations from a timeline model, checked by a separate monitor.
module tb_poly_audio_player;
  localparam int CH = 2, FB = 3, PW = 8, DW = 4, SEQ = 4, SMP = 2, DEPTH = 8, MAXL = 400;

  logic          clk = 1'b0;
  logic          reset, wr_en, start, stop, loop;
  logic          wr_ch;
  logic [FB-1:0] wr_addr;
  logic [PW-1:0] wr_period;
  logic [DW-1:0] wr_dur;
  logic [CH-1:0] ch_mask;
  logic [1:0]    octave = 2'd0;
  logic [CH-1:0] busy, audio_ch;
  logic          done, audio;

  always #5 clk = ~clk;

  poly_audio_player #(
    .CHANNELS(CH), .FRAME_BITS(FB), .PERIOD_WIDTH(PW), .DUR_WIDTH(DW),
    .SEQ_DIV(SEQ), .SAMPLE_DIV(SMP)
  ) dut (
    .CLK(clk), .RESET(reset),
`ifdef POLY_AUDIO_TRANSPOSE_EN
    .OCTAVE(octave),
`endif
    .WR_EN(wr_en), .WR_CH(wr_ch), .WR_ADDR(wr_addr), .WR_PERIOD(wr_period), .WR_DUR(wr_dur),
    .START(start), .CH_MASK(ch_mask), .STOP(stop), .LOOP(loop),
    .BUSY(busy), .DONE(done), .AUDIO_CH(audio_ch), .AUDIO(audio)
  );

  typedef struct {
    int            cyc;
    logic [CH-1:0] busy;
    logic          done;
    logic [CH-1:0] ach;
    logic          aud;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   tblp [CH][DEPTH];
  int   tbld [CH][DEPTH];
  logic eb [CH][MAXL];
  logic ea [CH][MAXL];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation at the cycle it names.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc || busy !== e.busy || done !== e.done || audio_ch !== e.ach || audio !== e.aud) begin
          errors++;
          $display("FAIL cyc%0d: got busy=%b done=%b audio_ch=%b audio=%b, want busy=%b done=%b audio_ch=%b audio=%b (entry cycle %0d)",
                   cyc, busy, done, audio_ch, audio, e.busy, e.done, e.ach, e.aud, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int eff(input int p);
    int s;
    s = p >> octave;
    if (p != 0 && s == 0) s = 1;
    return s;
  endfunction

  // Channel timeline relative to the START edge: sequencer ticks at SEQ*k, sample ticks at SMP*j.
  task automatic model_ch(input int c, input int len, input logic lp);
    int l, fr, p, d, pe, k0, e, nt;
    for (int r = 0; r < len; r++) begin eb[c][r] = 1'b0; ea[c][r] = 1'b0; end
    l = 0; fr = 0;
    while (l < len) begin
      p = tblp[c][fr]; d = tbld[c][fr];
      eb[c][l] = 1'b1;
      if (p == 0 && d == 0) begin
        if (!lp) break;
        fr = 0; l = l + 1;
      end else begin
        pe = eff(p);
        k0 = (l + 2 + SEQ - 1) / SEQ;
        e  = (k0 + d) * SEQ;
        for (int n = l + 1; n < e && n < len; n++) begin
          eb[c][n] = 1'b1;
          nt = n / SMP - (l + 1) / SMP;
          ea[c][n] = (pe != 0) && (((nt / pe) % 2) == 1);
        end
        fr = (fr + 1) % DEPTH;
        l = e;
      end
    end
  endtask

  task automatic predict(input int t0, input logic [CH-1:0] mask, input logic lp,
                         input int stop_rel, input int rst_rel, input int len);
    exp_t e;
    logic [CH-1:0] bp, bpp, ap;
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) model_ch(c, len, lp);
      else for (int r = 0; r < len; r++) begin eb[c][r] = 1'b0; ea[c][r] = 1'b0; end
    end
    bp = '0; bpp = '0; ap = '0;
    for (int r = 0; r < len; r++) begin
      e.cyc = t0 + r;
      for (int c = 0; c < CH; c++) begin
        e.busy[c] = eb[c][r];
        e.ach[c]  = ea[c][r];
      end
      if ((stop_rel >= 0 && r >= stop_rel) || (rst_rel >= 0 && r >= rst_rel)) begin
        e.busy = '0; e.ach = '0;
      end
      e.done = (bpp != '0) && (bp == '0);
      e.aud  = ^ap;
      if (rst_rel >= 0 && r >= rst_rel) begin e.done = 1'b0; e.aud = 1'b0; end
      q.push_back(e);
      bpp = bp; bp = e.busy; ap = e.ach;
    end
  endtask

  task automatic wr(input int c, input int a, input int p, input int d);
    wr_en = 1'b1; wr_ch = c[0]; wr_addr = a[FB-1:0]; wr_period = p[PW-1:0]; wr_dur = d[DW-1:0];
    tblp[c][a] = p; tbld[c][a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One playback window: START at relative edge 0, optional STOP/RESET/extra START later.
  task automatic run(input logic [CH-1:0] mask, input logic lp, input int stop_rel,
                     input int rst_rel, input int extra_rel, input int len);
    int t0;
    @(negedge clk);
    t0 = cyc + 1;
    predict(t0, mask, lp, stop_rel, rst_rel, len);
    start = 1'b1; ch_mask = mask; loop = lp; stop = (stop_rel == 0);
    @(negedge clk);
    for (int r = 1; r <= len + 2; r++) begin
      stop    = (r == stop_rel);
      reset   = (r == rst_rel);
      start   = (r == extra_rel);
      ch_mask = (r == extra_rel) ? 2'b11 : 2'b00;
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0; ch_mask = '0; loop = 1'b0;
  endtask

  initial begin
    exp_t z;
    int sr;
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_ch = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0; ch_mask = '0;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      z.cyc = cyc + i; z.busy = '0; z.done = 1'b0; z.ach = '0; z.aud = 1'b0;
      q.push_back(z);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int c = 0; c < CH; c++)
      for (int a = 0; a < DEPTH; a++) wr(c, a, 0, 0);

    // Single tone frame then terminator, one shot.
    wr(0, 0, 3, 1); wr(0, 1, 0, 0);
    wr(1, 0, 3, 2); wr(1, 1, 0, 0);
    run(2'b01, 1'b0, -1, -1, -1, 20);
    // Looping until STOP.
    run(2'b01, 1'b1, 40, -1, -1, 45);
    // START while busy is ignored, including the ch1 request.
    run(2'b01, 1'b0, -1, -1, 3, 20);
    // STOP and START together: nothing starts.
    run(2'b11, 1'b0, 0, -1, -1, 6);

    // Rest on ch0 alongside a short tone on ch1.
    wr(0, 0, 0, 2); wr(0, 1, 0, 0);
    wr(1, 0, 5, 0); wr(1, 1, 0, 0);
    run(2'b11, 1'b0, -1, -1, -1, 25);

    // No terminator: index wraps, then RESET mid-frame, then replay from retained table.
    for (int a = 0; a < DEPTH; a++) wr(0, a, 2, 0);
    run(2'b01, 1'b0, -1, 46, -1, 50);
    run(2'b01, 1'b0, 20, -1, -1, 24);

    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < CH; c++)
        for (int a = 0; a < DEPTH; a++) begin
          if ($urandom_range(0, 3) == 0) wr(c, a, 0, 0);
          else wr(c, a, $urandom_range(0, 5), $urandom_range(0, 3));
        end
      sr = $urandom_range(5, 150);
      run(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), sr, -1, -1, sr + 4);
    end

`ifdef POLY_AUDIO_TRANSPOSE_EN
    wr(0, 0, 8, 7); wr(0, 1, 0, 0);
    octave = 2'd1;
    run(2'b01, 1'b0, -1, -1, -1, 45);
    wr(0, 0, 4, 3);
    octave = 2'd3;
    run(2'b01, 1'b0, -1, -1, -1, 25);
    octave = 2'd0;
`endif

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_audio_player.md
POLY_AUDIO_PLAYER -- requirements
Module: poly_audio_player

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent voices (1..4).
REQ-002 SHALL have parameter FRAME_BITS, default 5, log2 of frame-table depth per channel.
REQ-003 SHALL have parameters PERIOD_WIDTH, default 16, and DUR_WIDTH, default 10, giving the frame field widths.
REQ-004 SHALL have parameters SEQ_DIV, default 48828, and SAMPLE_DIV, default 128, giving the sequencer-tick and sample-tick periods in clocks.
REQ-005 SHALL have ports: CLK in 1, sole clock; RESET in 1, synchronous active-high reset.
REQ-006 SHALL have ports: WR_EN in 1; WR_CH in clog2(CHANNELS); WR_ADDR in FRAME_BITS; WR_PERIOD in PERIOD_WIDTH; WR_DUR in DUR_WIDTH; together these are the frame-table write port.
REQ-007 SHALL have ports: START in 1, one-cycle pulse; CH_MASK in CHANNELS, channels to start; STOP in 1; LOOP in 1.
REQ-008 SHALL have ports: BUSY out CHANNELS, per-channel playing flag; DONE out 1, completion pulse; AUDIO_CH out CHANNELS, per-channel square wave; AUDIO out 1, mixed output.

Function
REQ-009 Frame table SHALL hold {period, dur} per channel per address; a write with WR_EN high SHALL take effect on the next edge, whether or not the channel is playing.
REQ-010 Each channel SHALL run the FSM IDLE -> LOAD -> PLAY -> (LOAD | IDLE).
REQ-011 START with BUSY==0 SHALL move each channel selected in CH_MASK to LOAD at frame 0; BUSY bit high 1 cycle after START.
REQ-012 START while any BUSY bit is high SHALL be ignored completely.
REQ-013 An accepted START SHALL clear both dividers; sequencer ticks then occur every SEQ_DIV clocks.
REQ-014 LOAD (one cycle) SHALL latch the period and dur of the current frame into channel registers, then enter PLAY.
REQ-015 In PLAY, frame position SHALL advance on each sequencer tick; the frame lasts dur+1 ticks, then the channel advances to frame+1 and returns to LOAD.
REQ-016 Frame index SHALL wrap from 2^FRAME_BITS-1 to 0.
REQ-017 Frame with period==0 and dur!=0 SHALL be a rest: AUDIO_CH low for its duration.
REQ-018 Frame with period==0 and dur==0 SHALL be a terminator: with LOOP high, the channel goes to LOAD at frame 0; with LOOP low, it goes to IDLE and its BUSY bit falls.
REQ-019 DONE SHALL pulse for exactly one cycle when the BUSY bus goes from nonzero to all-zero, whether by terminators or by STOP.
REQ-020 STOP SHALL force all channels to IDLE next cycle and silence AUDIO_CH; STOP beats START in the same cycle.
REQ-021 Tone generation: per channel, a counter SHALL advance on each sample tick (every SAMPLE_DIV clocks); AUDIO_CH toggles and the counter clears when the counter reaches period-1.
REQ-022 AUDIO_CH SHALL be 0 in IDLE, LOAD and rests; the tone starts low at frame entry.
REQ-023 AUDIO SHALL be the XOR of all AUDIO_CH bits, registered (1 cycle latency).

Reset
REQ-024 RESET SHALL set all channels to IDLE, BUSY=0, DONE=0, AUDIO_CH=0, AUDIO=0, and clear the dividers, frame indices and tone counters.
REQ-025 RESET mid-playback SHALL take priority over all inputs, and SHALL NOT assert DONE.
REQ-026 Frame-table contents SHALL NOT be cleared by RESET.

Configuration
REQ-027 With macro POLY_AUDIO_TRANSPOSE_EN defined, port OCTAVE in 2 SHALL exist; the latched period used for tone generation is period>>OCTAVE, applied at LOAD, and a nonzero period shifted to 0 is treated as 1.
REQ-028 Without POLY_AUDIO_TRANSPOSE_EN, port OCTAVE SHALL be absent and the period SHALL be used unshifted.

Verification (CHANNELS=2, SEQ_DIV=4, SAMPLE_DIV=2, FRAME_BITS=3)
REQ-029 Ch0 frames {3,1},{0,0}; START with CH_MASK=01 -> BUSY[0] high 2 frame-duration ticks (8 clocks after LOAD); AUDIO_CH[0] toggles every 6 clocks; DONE pulses once; BUSY=00.
REQ-030 Same table with LOOP=1 -> frame 0 replays indefinitely; DONE never asserts; STOP -> AUDIO_CH=00 next cycle, DONE one pulse.
REQ-031 Second START while BUSY=01 -> ignored, CH_MASK=11 has no effect on ch1; STOP+START same cycle -> stays IDLE.
REQ-032 Ch0 rest {0,2} then {0,0}, ch1 {5,0},{0,0}, CH_MASK=11 -> AUDIO equals AUDIO_CH[1] delayed 1 cycle; DONE only after ch0's rest ends.
REQ-033 All 8 frames {2,0}, no terminator -> index wraps 7 -> 0 and BUSY stays high; RESET mid-frame -> all outputs 0 next cycle, no DONE, and table retained (second START replays).
REQ-034 With POLY_AUDIO_TRANSPOSE_EN, OCTAVE=1 and period 8 -> toggles every 8 clocks; OCTAVE=3, period 4 -> effective period 1 (not a rest).
